rs_err_loc_scan: RTL

- Downstream consumer of the additive FFT in the RS decode path of decap.
- Scans the 256-entry FFT result RAM (σ evaluated at every GF(2^8) element) for roots of the error-locator polynomial.
- Maps each root to an RS codeword position and produces an N1-bit error-position vector, an error count and a decoding-failure flag.
- Output feeds the error-value (Forney) stage.

---
 rtl/rs_pkg.sv | 34 +++
 rtl/gf256_log_rom.sv | 17 +
 rtl/rs_err_loc_scan.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared RS decode definitions: field polynomial, code parameters per security level, scan FSM states.
// Also builds the GF(2^8) discrete-log table at elaboration time.
package rs_pkg;

   localparam logic [8:0] GF_POLY = 9'h11D;

   localparam int N1_128    = 46;
   localparam int DELTA_128 = 15;
   localparam int N1_192    = 56;
   localparam int DELTA_192 = 16;
   localparam int N1_256    = 90;
   localparam int DELTA_256 = 29;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } scan_state_t;

   // Walk alpha^i for i=0..254 and record i at index alpha^i; entry 0 is unused.
   function automatic logic [255:0][7:0] gen_log_tbl();
      logic [255:0][7:0] tbl;
      logic [7:0]        x;
      tbl = '0;
      x   = 8'h01;
      for (int i = 0; i < 255; i++) begin
         tbl[x] = 8'(i);
         x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
      end
      return tbl;
   endfunction

endpackage

// File: rtl/gf256_log_rom.sv
// GF(2^8) discrete log (base alpha=0x02, poly 0x11D); registered output, 1-cycle latency.
// Input 0 has no logarithm and yields a don't-care value.
module gf256_log_rom
   import rs_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] elem,
   output logic [7:0] log_val
);

   localparam logic [255:0][7:0] LOG_TBL = gen_log_tbl();

   always_ff @(posedge clk) begin
      log_val <= LOG_TBL[elem];
   end

endmodule

// File: rtl/rs_err_loc_scan.sv
// Error-locator root scan over the FFT result RAM; builds error vector, count and failure flag in 257 cycles.
// Optional position stream enabled by RS_ERR_LOC_SCAN_POS_STREAM_EN.
module rs_err_loc_scan
   import rs_pkg::*;
#(
   parameter int N1    = N1_128,
   parameter int DELTA = DELTA_128,
   parameter int AW    = 8,
   parameter int DW    = 8
)(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [AW-1:0]            ram_addr_o,
   output logic                     ram_rd_o,
   input  logic [DW-1:0]            ram_dout_i,
   output logic [N1-1:0]            err_vec_o,
   output logic [$clog2(N1+1)-1:0]  err_cnt_o,
   output logic                     fail_o
`ifdef RS_ERR_LOC_SCAN_POS_STREAM_EN
   ,
   output logic [7:0]               pos_o,
   output logic                     pos_vld_o
`endif
);

   localparam int         CW    = $clog2(N1+1);
   localparam logic [7:0] N1_B  = 8'(N1);

   scan_state_t   state, state_nxt;
   logic [AW-1:0] addr;
   logic          rd_dly;
   logic          clr;
   logic [7:0]    log_l;
   logic [7:0]    k;
   logic          hit;
   logic [CW-1:0] cnt_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      ram_rd_o  = 1'b0;
      clr       = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = READ;
               clr       = 1'b1;
            end
         end
         READ: begin
            busy_o   = 1'b1;
            ram_rd_o = 1'b1;
            if (&addr) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy_o    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            busy_o    = 1'b1;
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ram_addr_o = ram_rd_o ? addr : '0;

   // Log is looked up from the issued address, so it lands in the same cycle as the read data.
   gf256_log_rom u_log_rom (
      .clk     (clk_i),
      .elem    (ram_addr_o[7:0]),
      .log_val (log_l)
   );

   assign k       = (log_l == 8'd0) ? 8'd0 : (8'hFF - log_l);
   assign hit     = rd_dly && (ram_dout_i == '0) && (k < N1_B);
   assign cnt_nxt = (hit && (err_cnt_o != CW'(N1))) ? err_cnt_o + CW'(1) : err_cnt_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr      <= '0;
         rd_dly    <= 1'b0;
         err_vec_o <= '0;
         err_cnt_o <= '0;
         fail_o    <= 1'b0;
      end else begin
         rd_dly <= ram_rd_o;
         if (clr) begin
            addr      <= AW'(1);
            err_vec_o <= '0;
            err_cnt_o <= '0;
            fail_o    <= 1'b0;
         end else begin
            if (state == READ) addr <= addr + AW'(1);
            if (hit) begin
               err_vec_o <= err_vec_o | ({{(N1-1){1'b0}}, 1'b1} << k);
               err_cnt_o <= cnt_nxt;
            end
            // Last data word is evaluated during DRAIN, so fold it in via cnt_nxt.
            if (state == DRAIN) fail_o <= (cnt_nxt > CW'(DELTA));
         end
      end
   end

`ifdef RS_ERR_LOC_SCAN_POS_STREAM_EN
   assign pos_vld_o = hit;
   assign pos_o     = hit ? k : 8'd0;
`endif

endmodule
